ntt_btf_sched: RTL

- Sequencer for the butterfly add/sub datapath across all stages of an in-place N-point Cooley-Tukey NTT.
- Each cycle it generates one butterfly's operand-pair read addresses and twiddle address.
- It tracks operands through the fixed-latency memory-read plus btf_addsub pipeline and emits delay-aligned write-back addresses.
- Sits between the top-level NTT controller (start/done) and the coefficient RAM / twiddle ROM / btf_addsub datapath.

---
 rtl/ntt_pkg.sv | 10 +
 rtl/ntt_btf_addr_gen.sv | 23 ++
 rtl/ntt_btf_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared scheduler state encoding and latency/width helpers
package ntt_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    function automatic int pipe_lat(input int rd_lat, input int btf_lat);
        return rd_lat + btf_lat;
    endfunction
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ntt_btf_addr_gen.sv
// btf_addr_gen: Cooley-Tukey operand-pair and twiddle address for (stage, k)
module btf_addr_gen #(
    parameter int LOGN = 8
) (
    input  logic [LOGN-1:0] stage,
    input  logic [LOGN-2:0] k,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-2:0] tw_addr
);
    logic [LOGN-1:0] m, kx, j, sh, tw_full;
    // split k into group g and offset j; a = g*2m + j, b = a + m, tw = j scaled to the ROM span
    always_comb begin
        m       = LOGN'(1) << stage;
        kx      = LOGN'(k);
        j       = kx & (m - 1'b1);
        sh      = LOGN'(LOGN - 1) - stage;
        addr_a  = ((kx >> stage) << (stage + 1'b1)) | j;
        addr_b  = addr_a + m;
        tw_full = j << sh;
        tw_addr = tw_full[LOGN-2:0];
    end
endmodule

// File: rtl/ntt_btf_sched.sv
// ntt_btf_sched: butterfly issue/write-back sequencer for an in-place NTT (optional NTT_SCHED_PERF_EN adds stall_cnt/cycle_cnt)
module ntt_btf_sched
    import ntt_pkg::*;
#(
    parameter int LOGN    = 8,
    parameter int RD_LAT  = 1,
    parameter int BTF_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] stage,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-2:0] tw_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
`ifdef NTT_SCHED_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     cycle_cnt
`endif
);
    localparam int PIPE_LAT = pipe_lat(RD_LAT, BTF_LAT);
    localparam int HALF     = 1 << (LOGN - 1);
    localparam int DW       = cnt_w(PIPE_LAT);

    state_t          state, state_n;
    logic [LOGN-2:0] k, k_n;
    logic [LOGN-1:0] stage_n, ga, gb;
    logic [LOGN-2:0] gt;
    logic [DW-1:0]   dcnt, dcnt_n;
    logic [PIPE_LAT-1:0] vd;
    logic [LOGN-1:0] da [PIPE_LAT];
    logic [LOGN-1:0] db [PIPE_LAT];

    btf_addr_gen #(.LOGN(LOGN)) u_gen (
        .stage   (stage),
        .k       (k),
        .addr_a  (ga),
        .addr_b  (gb),
        .tw_addr (gt)
    );

    // state, butterfly index, stage and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            stage <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            stage <= stage_n;
            dcnt  <= dcnt_n;
        end
    end

    // next-state and issue decode; drain waits out the pipeline so writes land before the next stage reads
    always_comb begin
        state_n = state;
        k_n     = k;
        stage_n = stage;
        dcnt_n  = dcnt;
        rd_en   = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                state_n = ISSUE;
                k_n     = '0;
                stage_n = '0;
            end
            ISSUE: if (!stall) begin
                rd_en = 1'b1;
                k_n   = k + 1'b1;
                if (k == (LOGN-1)'(HALF - 1)) begin
                    state_n = DRAIN;
                    dcnt_n  = '0;
                end
            end
            DRAIN: begin
                dcnt_n = dcnt + 1'b1;
                if (dcnt == DW'(PIPE_LAT - 1)) begin
                    if (stage == LOGN'(LOGN - 1)) state_n = DONE;
                    else begin
                        state_n = ISSUE;
                        stage_n = stage + 1'b1;
                        k_n     = '0;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        rd_addr_a = rd_en ? ga : '0;
        rd_addr_b = rd_en ? gb : '0;
        tw_addr   = rd_en ? gt : '0;
    end

    assign busy = (state == ISSUE) || (state == DRAIN);
    assign done = (state == DONE);

    // write-back delay line, independent of stall; reset drops in-flight writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vd <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                da[i] <= '0;
                db[i] <= '0;
            end
        end else begin
            vd[0] <= rd_en;
            da[0] <= rd_addr_a;
            db[0] <= rd_addr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vd[i] <= vd[i-1];
                da[i] <= da[i-1];
                db[i] <= db[i-1];
            end
        end
    end

    assign wr_en     = vd[PIPE_LAT-1];
    assign wr_addr_a = da[PIPE_LAT-1];
    assign wr_addr_b = db[PIPE_LAT-1];

`ifdef NTT_SCHED_PERF_EN
    // run statistics: cleared on start acceptance, held after done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy) cycle_cnt <= cycle_cnt + 1'b1;
            if (state == ISSUE && stall) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif
endmodule
